debug_capture: RTL and testbench

Bus-snooping capture stage that sits directly upstream of the on-screen debug overlay and drives its 64-bit `i_debug` word. It watches CPU write cycles, builds a 64-bit status word of 16 hex nibbles, and publishes it once per frame on the rising edge of vertical blank, so the overlay never shows a half-updated value mid-frame. An optional trigger freezes the published word after a chosen write, holding it for inspection until re-armed.

---
 rtl/debug_capture_if.sv | 12 +
 rtl/debug_capture.sv | 134 +++++++++++++
 tb/tb_debug_capture.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/debug_capture_if.sv
// CPU write-bus bundle snooped by the debug capture stage.
// A bus write is qualified as ce & wr; there is no back-pressure, the
// snooper only observes, so the bus side never waits on it.
interface debug_capture_if;
   logic        ce;
   logic        wr;
   logic [15:0] addr;
   logic [7:0]  data;

   modport master (output ce, output wr, output addr, output data);
   modport slave  (input  ce, input  wr, input  addr, input  data);
endinterface

// File: rtl/debug_capture.sv
// Bus-snooping capture stage feeding the on-screen debug overlay.
// Collects CPU write activity into a 64-bit status word and publishes it once
// per frame on the vblank rising edge. An optional trigger freezes the
// published word after a chosen write until the block is re-armed.
module debug_capture #(
   parameter logic [15:0] WATCH_ADDR = 16'h0000,
   parameter logic [7:0]  TRIG_DATA  = 8'h00,
   parameter bit          TRIG_EN    = 1'b1
) (
   input  logic                   clk,
   input  logic                   i_reset_n,
   debug_capture_if.slave         bus,
   input  logic                   i_vblank,
   input  logic                   i_rearm,
   output logic [63:0]            o_debug,
   output logic                   o_stb,
   output logic                   o_frozen,
   output logic [1:0]             o_state     // FSM state, for debug/checkers
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_HOLD   = 2'd1,
      ST_FROZEN = 2'd2
   } state_e;

   state_e      state_q, state_d;

   logic        vb_d_q;
   logic [15:0] s_addr_q,  s_addr_d;
   logic [7:0]  s_data_q,  s_data_d;
   logic [7:0]  s_watch_q, s_watch_d;
   logic [15:0] wcnt_q,    wcnt_d;
   logic [15:0] fcnt_q,    fcnt_d;
   logic [63:0] debug_q,   debug_d;
   logic        stb_q;

   logic        we;
   logic        vb_rise;
   logic        trigger;
   logic        publish;
   logic        frozen;

   // Bus write qualification, vblank edge and trigger match
   always_comb begin
      we      = bus.ce & bus.wr;
      vb_rise = i_vblank & ~vb_d_q;
      trigger = TRIG_EN & we & (bus.addr == WATCH_ADDR) & (bus.data == TRIG_DATA);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!i_reset_n) state_q <= ST_RUN;
      else            state_q <= state_d;
   end

   // FSM next state; re-arm outranks a trigger seen in the same cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (!i_rearm && trigger) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (i_rearm)      state_d = ST_RUN;
            else if (vb_rise) state_d = ST_FROZEN;
         end
         ST_FROZEN: begin
            if (i_rearm) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // FSM outputs: publish in RUN and HOLD, freeze indication in FROZEN
   always_comb begin
      publish = vb_rise & (state_q != ST_FROZEN);
      frozen  = (state_q == ST_FROZEN);
   end

   // Datapath next values; the publish snapshot uses pre-write contents so a
   // write landing on the publish cycle is counted in the following frame
   always_comb begin
      s_addr_d  = s_addr_q;
      s_data_d  = s_data_q;
      s_watch_d = s_watch_q;
      wcnt_d    = wcnt_q;
      fcnt_d    = fcnt_q;
      debug_d   = debug_q;
      if (we) begin
         s_addr_d = bus.addr;
         s_data_d = bus.data;
         if (bus.addr == WATCH_ADDR) s_watch_d = bus.data;
      end
      if (vb_rise) begin
         fcnt_d = fcnt_q + 16'd1;
         wcnt_d = {15'd0, we};
      end else if (we && (wcnt_q != 16'hFFFF)) begin
         wcnt_d = wcnt_q + 16'd1;
      end
      if (publish) begin
         debug_d = {fcnt_q + 16'd1, wcnt_q, s_watch_q, s_data_q, s_addr_q};
      end
   end

   // Datapath registers; vb_d resets high so vblank already high at release is not an edge
   always_ff @(posedge clk) begin
      if (!i_reset_n) begin
         vb_d_q    <= 1'b1;
         s_addr_q  <= 16'd0;
         s_data_q  <= 8'd0;
         s_watch_q <= 8'd0;
         wcnt_q    <= 16'd0;
         fcnt_q    <= 16'd0;
         debug_q   <= 64'd0;
         stb_q     <= 1'b0;
      end else begin
         vb_d_q    <= i_vblank;
         s_addr_q  <= s_addr_d;
         s_data_q  <= s_data_d;
         s_watch_q <= s_watch_d;
         wcnt_q    <= wcnt_d;
         fcnt_q    <= fcnt_d;
         debug_q   <= debug_d;
         stb_q     <= publish;
      end
   end

   assign o_debug  = debug_q;
   assign o_stb    = stb_q;
   assign o_frozen = frozen;
   assign o_state  = state_q;

endmodule

// File: tb/tb_debug_capture.sv
// Directed testbench for debug_capture: frame publishing, write counting,
// counter saturation, trigger/freeze/re-arm and mid-operation reset.
module tb_debug_capture;

   localparam logic [1:0] ST_RUN    = 2'd0;
   localparam logic [1:0] ST_HOLD   = 2'd1;
   localparam logic [1:0] ST_FROZEN = 2'd2;

   logic        clk;
   logic        i_reset_n;
   logic        i_vblank;
   logic        i_rearm;
   logic [63:0] o_debug;
   logic        o_stb;
   logic        o_frozen;
   logic [1:0]  o_state;

   int n_checks = 0;
   int n_errors = 0;

   logic [63:0] exp_q[$];

   debug_capture_if bus_if ();

   debug_capture #(
      .WATCH_ADDR (16'h0010),
      .TRIG_DATA  (8'h5C),
      .TRIG_EN    (1'b1)
   ) dut (
      .clk       (clk),
      .i_reset_n (i_reset_n),
      .bus       (bus_if.slave),
      .i_vblank  (i_vblank),
      .i_rearm   (i_rearm),
      .o_debug   (o_debug),
      .o_stb     (o_stb),
      .o_frozen  (o_frozen),
      .o_state   (o_state)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // scoreboard: every strobe must match the next expected publish
   always @(negedge clk) begin
      if (i_reset_n && o_stb === 1'b1) begin
         if (exp_q.size() == 0) check("unexpected_stb", o_debug, 64'hDEAD_DEAD_DEAD_DEAD);
         else                   check("publish", o_debug, exp_q.pop_front());
      end
   end

   // driver tasks: inputs change after negedge, outputs read at negedge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic bus_idle();
      bus_if.ce   = 1'b0;
      bus_if.wr   = 1'b0;
      bus_if.addr = 16'h0000;
      bus_if.data = 8'h00;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d, input logic rearm);
      bus_if.ce   = 1'b1;
      bus_if.wr   = 1'b1;
      bus_if.addr = a;
      bus_if.data = d;
      i_rearm     = rearm;
      step();
      bus_idle();
      i_rearm = 1'b0;
   endtask

   // One frame edge; optionally a write in the very cycle of the rise.
   // exp is the expected o_debug after the edge (held value when no publish).
   task automatic frame(input string tag, input logic [63:0] exp, input logic exp_pub,
                        input logic do_wr, input logic [15:0] a, input logic [7:0] d);
      if (exp_pub) exp_q.push_back(exp);
      i_vblank = 1'b1;
      if (do_wr) begin
         bus_if.ce = 1'b1; bus_if.wr = 1'b1; bus_if.addr = a; bus_if.data = d;
      end
      step();
      bus_idle();
      check({tag, "_stb"}, {63'd0, o_stb}, {63'd0, exp_pub});
      check({tag, "_debug"}, o_debug, exp);
      step();
      check({tag, "_stb_single"}, {63'd0, o_stb}, 64'd0);
      i_vblank = 1'b0;
      step();
   endtask

   initial begin
      i_reset_n = 1'b0;
      i_vblank  = 1'b1;
      i_rearm   = 1'b0;
      bus_idle();
      repeat (3) step();
      check("reset_debug",  o_debug, 64'd0);
      check("reset_stb",    {63'd0, o_stb}, 64'd0);
      check("reset_frozen", {63'd0, o_frozen}, 64'd0);
      check("reset_state",  {62'd0, o_state}, {62'd0, ST_RUN});

      // vblank already high at release: no publish
      i_reset_n = 1'b1;
      step();
      check("release_no_stb", {63'd0, o_stb}, 64'd0);
      step();
      check("release_no_stb2", {63'd0, o_stb}, 64'd0);
      i_vblank = 1'b0;
      step();
      frame("first_frame", 64'h0001_0000_0000_0000, 1'b1, 1'b0, 16'h0, 8'h0);

      // three writes; the watch write carries a concurrent rearm so no trigger
      bus_write(16'h1234, 8'hAB, 1'b0);
      bus_write(16'h0010, 8'h5C, 1'b1);
      check("rearm_beats_trigger_state", {62'd0, o_state}, {62'd0, ST_RUN});
      bus_write(16'hBEEF, 8'h07, 1'b0);
      frame("three_writes", 64'h0002_0003_5C07_BEEF, 1'b1, 1'b0, 16'h0, 8'h0);
      check("rearm_beats_trigger_frozen", {63'd0, o_frozen}, 64'd0);
      frame("empty_frame", 64'h0003_0000_5C07_BEEF, 1'b1, 1'b0, 16'h0, 8'h0);

      // write landing in the rise cycle belongs to the next frame
      bus_write(16'h1234, 8'hAB, 1'b0);
      frame("edge_write", 64'h0004_0001_5CAB_1234, 1'b1, 1'b1, 16'hBEEF, 8'h07);
      frame("edge_write_next", 64'h0005_0001_5C07_BEEF, 1'b1, 1'b0, 16'h0, 8'h0);

      // write counter saturation
      bus_if.ce = 1'b1; bus_if.wr = 1'b1; bus_if.addr = 16'h2222; bus_if.data = 8'h33;
      repeat (70000) step();
      bus_idle();
      frame("wcnt_saturate", 64'h0006_FFFF_5C33_2222, 1'b1, 1'b0, 16'h0, 8'h0);
      frame("wcnt_cleared", 64'h0007_0000_5C33_2222, 1'b1, 1'b0, 16'h0, 8'h0);

      // trigger, HOLD publish, then frozen frames
      bus_write(16'h0010, 8'h5C, 1'b0);
      check("trigger_hold", {62'd0, o_state}, {62'd0, ST_HOLD});
      frame("hold_publish", 64'h0008_0001_5C5C_0010, 1'b1, 1'b0, 16'h0, 8'h0);
      check("frozen_set", {63'd0, o_frozen}, 64'd1);
      check("frozen_state", {62'd0, o_state}, {62'd0, ST_FROZEN});
      bus_write(16'h4444, 8'h11, 1'b0);
      frame("frozen_1", 64'h0008_0001_5C5C_0010, 1'b0, 1'b0, 16'h0, 8'h0);
      bus_write(16'h5555, 8'h22, 1'b0);
      frame("frozen_2", 64'h0008_0001_5C5C_0010, 1'b0, 1'b0, 16'h0, 8'h0);
      check("still_frozen", {63'd0, o_frozen}, 64'd1);
      i_rearm = 1'b1;
      step();
      i_rearm = 1'b0;
      check("rearm_frozen_clear", {63'd0, o_frozen}, 64'd0);
      check("rearm_state", {62'd0, o_state}, {62'd0, ST_RUN});
      frame("after_rearm", 64'h000B_0000_5C22_5555, 1'b1, 1'b0, 16'h0, 8'h0);

      // mid-operation reset from HOLD
      bus_write(16'h0010, 8'h5C, 1'b0);
      check("pre_reset_hold", {62'd0, o_state}, {62'd0, ST_HOLD});
      i_reset_n = 1'b0;
      step();
      check("midreset_debug", o_debug, 64'd0);
      check("midreset_state", {62'd0, o_state}, {62'd0, ST_RUN});
      i_reset_n = 1'b1;
      step();
      frame("post_reset_frame", 64'h0001_0000_0000_0000, 1'b1, 1'b0, 16'h0, 8'h0);

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
